// File: rtl/alu_wb_regfile_if.sv
// alu_wb_regfile_if: ALU write-back, operand read and status signals
interface alu_wb_regfile_if;
  logic        wb_valid;
  logic        wb_ready;
  logic [3:0]  wb_ctrl;
  logic [3:0]  wb_dest;
  logic [15:0] wb_res;
  logic [15:0] wb_r15;
  logic [3:0]  rd_addr_a;
  logic [3:0]  rd_addr_b;
  logic [15:0] rd_data_a;
  logic [15:0] rd_data_b;
  logic        err_illegal;
  logic [15:0] ops_retired;
  modport master (
    output wb_valid, wb_ctrl, wb_dest, wb_res, wb_r15, rd_addr_a, rd_addr_b,
    input  wb_ready, rd_data_a, rd_data_b, err_illegal, ops_retired
  );
  modport slave (
    input  wb_valid, wb_ctrl, wb_dest, wb_res, wb_r15, rd_addr_a, rd_addr_b,
    output wb_ready, rd_data_a, rd_data_b, err_illegal, ops_retired
  );
endinterface

// File: rtl/alu_wb_regfile.sv
// alu_wb_regfile: 16x16 register file with ALU write-back and MUL/DIV R15 second write
module alu_wb_regfile (
  input logic            clk,
  input logic            rst_n,
  alu_wb_regfile_if.slave bus
);
  typedef enum logic {IDLE, WR_R15} state_t;
  state_t      state, state_nx;
  logic [15:0] rf [16];
  logic [15:0] hold;
  logic [15:0] ops;
  logic        err;
  logic        hs, legal, muldiv;
  assign hs              = bus.wb_valid & bus.wb_ready;
  assign legal           = bus.wb_ctrl <= 4'd5;
  assign muldiv          = bus.wb_ctrl[3:1] == 3'b001;
  assign bus.wb_ready    = state == IDLE;
  assign bus.rd_data_a   = rf[bus.rd_addr_a];
  assign bus.rd_data_b   = rf[bus.rd_addr_b];
  assign bus.err_illegal = err;
  assign bus.ops_retired = ops;
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  // MUL/DIV spend one extra cycle writing R15; WR_R15 always returns to IDLE
  always_comb begin
    state_nx = IDLE;
    if (state == IDLE && hs && muldiv) state_nx = WR_R15;
  end
  // register writes; R0 is never written so it reads 0
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) rf[i] <= '0;
    end else if (hs && legal && bus.wb_dest != 4'd0) begin
      rf[bus.wb_dest] <= bus.wb_res;
    end else if (state == WR_R15) begin
      rf[15] <= hold;
    end
  // holding register, illegal-op pulse and retired-op counter
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      hold <= '0;
      err  <= 1'b0;
      ops  <= '0;
    end else begin
      if (hs && muldiv) hold <= bus.wb_r15;
      err <= hs & ~legal;
      ops <= ops + 16'(hs);
    end
endmodule

// File: tb/tb_alu_wb_regfile.sv
// tb_alu_wb_regfile: directed vectors with a queue-based scoreboard and negedge monitor
module tb_alu_wb_regfile;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  alu_wb_regfile_if bus();
  alu_wb_regfile dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  typedef struct {
    string       n;
    logic [15:0] a, b;
    logic        r, e;
    logic [15:0] o;
  } exp_t;
  exp_t q[$];
  event ev;
  int pass = 0;
  int total = 0;
  task automatic chk(input string n, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act === exp) pass++;
    else $display("FAIL %s: got %h want %h", n, act, exp);
  endtask
  // monitor: compares every queued expectation against live DUT outputs
  initial forever begin
    @(negedge clk or ev);
    while (q.size() != 0) begin
      exp_t x;
      x = q.pop_front();
      chk({x.n, ".rd_a"}, bus.rd_data_a, x.a);
      chk({x.n, ".rd_b"}, bus.rd_data_b, x.b);
      chk({x.n, ".ready"}, 16'(bus.wb_ready), 16'(x.r));
      chk({x.n, ".err"}, 16'(bus.err_illegal), 16'(x.e));
      chk({x.n, ".ops"}, bus.ops_retired, x.o);
    end
  end
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  task automatic cyc(input logic v, input logic [3:0] c, input logic [3:0] d,
                     input logic [15:0] r, input logic [15:0] h, input bit ck,
                     input string n, input logic [3:0] aa, input logic [3:0] ab,
                     input logic [15:0] ea, input logic [15:0] eb,
                     input logic er, input logic ee, input logic [15:0] eo);
    bus.wb_valid = v;
    bus.wb_ctrl  = c;
    bus.wb_dest  = d;
    bus.wb_res   = r;
    bus.wb_r15   = h;
    @(posedge clk);
    #1;
    if (ck) begin
      bus.rd_addr_a = aa;
      bus.rd_addr_b = ab;
      q.push_back('{n, ea, eb, er, ee, eo});
    end
  endtask
  initial begin
    int k;
    bus.wb_valid  = 1'b0;
    bus.wb_ctrl   = '0;
    bus.wb_dest   = '0;
    bus.wb_res    = '0;
    bus.wb_r15    = '0;
    bus.rd_addr_a = 4'd3;
    bus.rd_addr_b = 4'd15;
    q.push_back('{"reset", 16'h0, 16'h0, 1'b1, 1'b0, 16'd0});
    #12 rst_n = 1'b1;
    cyc(1, 4'h0, 4'd3,  16'h1234, 16'h0,    1, "add",      4'd3,  4'd15, 16'h1234, 16'h0,    1, 0, 16'd1);
    cyc(1, 4'h2, 4'd4,  16'h5678, 16'h0001, 1, "mul",      4'd4,  4'd15, 16'h5678, 16'h0,    0, 0, 16'd2);
    cyc(1, 4'h2, 4'd6,  16'h1111, 16'h9999, 1, "mul_wr15", 4'd6,  4'd15, 16'h0,    16'h0001, 1, 0, 16'd2);
    cyc(1, 4'h3, 4'd15, 16'h0007, 16'h0002, 1, "div_d15",  4'd15, 4'd4,  16'h0007, 16'h5678, 0, 0, 16'd3);
    cyc(0, 4'h0, 4'd0,  16'h0,    16'h0,    1, "div_wr15", 4'd15, 4'd6,  16'h0002, 16'h0,    1, 0, 16'd3);
    cyc(1, 4'h0, 4'd0,  16'hFFFF, 16'h0,    1, "add_r0",   4'd0,  4'd15, 16'h0,    16'h0002, 1, 0, 16'd4);
    cyc(1, 4'h7, 4'd5,  16'hAAAA, 16'h0,    1, "illegal",  4'd5,  4'd15, 16'h0,    16'h0002, 1, 1, 16'd5);
    cyc(0, 4'h0, 4'd0,  16'h0,    16'h0,    1, "err_off",  4'd5,  4'd3,  16'h0,    16'h1234, 1, 0, 16'd5);
    cyc(1, 4'h0, 4'd1,  16'h0011, 16'h0,    1, "b2b_add",  4'd1,  4'd15, 16'h0011, 16'h0002, 1, 0, 16'd6);
    cyc(1, 4'h4, 4'd2,  16'h0022, 16'hBEEF, 1, "b2b_and",  4'd2,  4'd15, 16'h0022, 16'h0002, 1, 0, 16'd7);
    cyc(1, 4'h5, 4'd7,  16'h00F0, 16'h0,    1, "b2b_or",   4'd7,  4'd1,  16'h00F0, 16'h0011, 1, 0, 16'd8);
    cyc(1, 4'h1, 4'd8,  16'h0F00, 16'h0,    1, "b2b_sub",  4'd8,  4'd2,  16'h0F00, 16'h0022, 1, 0, 16'd9);
    cyc(1, 4'hF, 4'd1,  16'h5555, 16'h0,    1, "ill_1111", 4'd1,  4'd15, 16'h0011, 16'h0002, 1, 1, 16'd10);
    cyc(0, 4'h0, 4'd0,  16'h0,    16'h0,    1, "idle",     4'd1,  4'd7,  16'h0011, 16'h00F0, 1, 0, 16'd10);
    for (int i = 0; i < 65524; i++)
      cyc(1, 4'h0, 4'd9, 16'(i), 16'h0, 0, "", 4'd0, 4'd0, 16'h0, 16'h0, 0, 0, 16'd0);
    cyc(1, 4'h0, 4'd9,  16'hCAFE, 16'h0,    1, "ops_ffff", 4'd9,  4'd15, 16'hCAFE, 16'h0002, 1, 0, 16'hFFFF);
    cyc(1, 4'h0, 4'd9,  16'h0001, 16'h0,    1, "ops_wrap", 4'd9,  4'd15, 16'h0001, 16'h0002, 1, 0, 16'h0000);
    cyc(1, 4'h2, 4'd10, 16'h1357, 16'hBEEF, 1, "mul_rst",  4'd10, 4'd15, 16'h1357, 16'h0002, 0, 0, 16'd1);
    bus.wb_valid = 1'b0;
    #6 rst_n = 1'b0;
    #1 q.push_back('{"async_rst", 16'h0, 16'h0, 1'b1, 1'b0, 16'd0});
    ->ev;
    #10 rst_n = 1'b1;
    cyc(0, 4'h0, 4'd0,  16'h0,    16'h0,    1, "post_rst", 4'd15, 4'd10, 16'h0,    16'h0,    1, 0, 16'd0);
    cyc(1, 4'h0, 4'd11, 16'h4321, 16'h0,    1, "rst_add",  4'd11, 4'd15, 16'h4321, 16'h0,    1, 0, 16'd1);
    bus.wb_valid = 1'b0;
    k = 0;
    while (q.size() != 0 && k < 10) begin
      @(posedge clk);
      k++;
    end
    if (q.size() != 0) begin
      total++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
